// File: rtl/inv_key_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_key_sched_pkg                                            |
// | Description : Shared AES-128 constants, types, Rcon table and fwd S-box.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package inv_key_sched_pkg;

    localparam int c_NR = 10;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  state_t;

    localparam state_t c_S_IDLE   = 2'd0;
    localparam state_t c_S_EXPAND = 2'd1;
    localparam state_t c_S_EMIT   = 2'd2;
    localparam state_t c_S_FIN    = 2'd3;

    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return c_SBOX[b];
    endfunction

    // Round constant used when stepping between round r-1 and round r.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_sched_sub_word.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_key_sched_sub_word                                       |
// | Description : SubWord - four parallel forward S-box lookups on a word.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module inv_key_sched_sub_word
    import inv_key_sched_pkg::*;
(
    input  word_t i_word,
    output word_t o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = aes_sbox(i_word[8*g +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/inv_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_key_sched                                                |
// | Description : Inverse AES-128 key schedule, emits round keys 10 down to 0. |
// |               Define INV_KEY_FWD_EN to accept the cipher key and expand    |
// |               forward to round 10 before emitting.                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module inv_key_sched
    import inv_key_sched_pkg::*;
#(
    parameter int NR = c_NR
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_LAST = 4'(NR);

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_round, w_round_nxt;

    word_t w_k0, w_k1, w_k2, w_k3;
    word_t w_inv0, w_inv1, w_inv2, w_inv3;
    word_t w_sub_in, w_sub_out;
    word_t w_rcon_word;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    assign {w_k0, w_k1, w_k2, w_k3} = r_key;
    assign w_rcon_word = {rcon(r_round), 24'h0};

    assign w_inv3 = w_k3 ^ w_k2;
    assign w_inv2 = w_k2 ^ w_k1;
    assign w_inv1 = w_k1 ^ w_k0;
    assign w_inv0 = w_k0 ^ w_sub_out ^ w_rcon_word;

`ifdef INV_KEY_FWD_EN
    word_t w_fwd0, w_fwd1, w_fwd2, w_fwd3;

    // One S-box layer serves both directions; EXPAND feeds the live w3.
    assign w_sub_in = (r_state == c_S_EXPAND) ? rot_word(w_k3) : rot_word(w_inv3);
    assign w_fwd0   = w_k0 ^ w_sub_out ^ w_rcon_word;
    assign w_fwd1   = w_k1 ^ w_fwd0;
    assign w_fwd2   = w_k2 ^ w_fwd1;
    assign w_fwd3   = w_k3 ^ w_fwd2;
`else
    assign w_sub_in = rot_word(w_inv3);
`endif

    inv_key_sched_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_key_nxt = key_in;
`ifdef INV_KEY_FWD_EN
                    w_round_nxt = 4'd1;
                    w_state_nxt = c_S_EXPAND;
`else
                    w_round_nxt = c_LAST;
                    w_state_nxt = c_S_EMIT;
`endif
                end
            end
`ifdef INV_KEY_FWD_EN
            c_S_EXPAND: begin
                w_key_nxt = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};
                if (r_round == c_LAST) begin
                    w_state_nxt = c_S_EMIT;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
`endif
            c_S_EMIT: begin
                if (rk_ready) begin
                    if (r_round == 4'd0) begin
                        w_state_nxt = c_S_FIN;
                    end else begin
                        w_key_nxt   = {w_inv0, w_inv1, w_inv2, w_inv3};
                        w_round_nxt = r_round - 4'd1;
                    end
                end
            end
            c_S_FIN:  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_key   <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
        end
    end

    assign rk_out   = r_key;
    assign rk_round = r_round;
    assign rk_valid = (r_state == c_S_EMIT);
    assign busy     = (r_state != c_S_IDLE);
    assign done     = (r_state == c_S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_inv_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_inv_key_sched                                             |
// | Description : Scoreboard bench for inv_key_sched (FIPS-197 + model keys).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_inv_key_sched;

    logic         CLK = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] key_in, rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid, busy, done;

    always #5 CLK = ~CLK;

    inv_key_sched dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .key_in(key_in),
        .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done)
    );

`ifdef INV_KEY_FWD_EN
    localparam int c_LAT = 11;
`else
    localparam int c_LAT = 1;
`endif

    typedef struct packed { logic [127:0] key; logic [3:0] round; } exp_t;
    exp_t q[$];

    int total = 0, bad = 0, n_done = 0;
    logic [127:0] fips [0:10];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent reference: S-box derived from GF(2^8) inverse + affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (a != 8'h00)
            for (int i = 1; i < 256; i++)
                if (gmul(a, 8'(i)) == 8'h01) b = 8'(i);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] m_subrot(input logic [31:0] w);
        logic [31:0] t;
        t = {w[23:0], w[31:24]};
        return {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
    endfunction

    function automatic logic [7:0] m_rcon(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        return rc;
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
        w0 = w0 ^ m_subrot(w3) ^ {m_rcon(r), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ m_subrot(w3) ^ {m_rcon(r), 24'h0};
        w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic push_model(input logic [127:0] key);
        logic [127:0] k;
        k = key;
`ifdef INV_KEY_FWD_EN
        for (int r = 1; r <= 10; r++) k = fwd_step(k, r);
`endif
        for (int r = 10; r >= 0; r--) begin
            q.push_back({k, 4'(r)});
            if (r > 0) k = inv_step(k, r);
        end
    endtask

    task automatic push_fips(input int lowest);
        for (int r = 10; r >= lowest; r--) q.push_back({fips[r], 4'(r)});
    endtask

    function automatic logic [127:0] fips_in();
`ifdef INV_KEY_FWD_EN
        return fips[0];
`else
        return fips[10];
`endif
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        start = 1'b1; key_in = k;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(rk_valid && rk_round == r) && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL wait_round: round %0d never presented within 100 cycles", r);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL wait_done: done not seen within 300 cycles");
        end
    endtask

    // Monitor: pops one expectation per accepted key; checks hold stability.
    logic         hold_prev = 1'b0;
    logic [127:0] hold_key;
    logic [3:0]   hold_round;
    always @(negedge CLK) begin
        exp_t e;
        if (done) n_done++;
        if (hold_prev && rk_valid) begin
            check("hold_key", rk_out, hold_key);
            check("hold_round", 128'(rk_round), 128'(hold_round));
        end
        hold_prev  = rk_valid && !rk_ready;
        hold_key   = rk_out;
        hold_round = rk_round;
        if (rk_valid && rk_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL xfer_unexpected: round %0d key %h with empty scoreboard", rk_round, rk_out);
            end else begin
                e = q.pop_front();
                check("xfer_key", rk_out, e.key);
                check("xfer_round", 128'(rk_round), 128'(e.round));
            end
        end
    end

    initial begin
        int d0;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b1;
        repeat (3) tick();
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_rk_round", 128'(rk_round), 128'h0);
        check("rst_rk_valid", 128'(rk_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_done", 128'(done), 128'h0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector, consumer always ready: cycle-exact latency checks.
        d0 = n_done;
        push_fips(0);
        do_start(fips_in());
        repeat (c_LAT - 1) tick();
        check("first_valid", 128'(rk_valid), 128'h1);
        check("first_round", 128'(rk_round), 128'd10);
        check("first_key", rk_out, fips[10]);
        check("first_busy", 128'(busy), 128'h1);
        tick();
        check("second_key", rk_out, fips[9]);
        check("second_round", 128'(rk_round), 128'd9);
        repeat (9) tick();
        check("last_round", 128'(rk_round), 128'd0);
        check("last_key", rk_out, fips[0]);
        tick();
        check("done_pulse", 128'(done), 128'h1);
        check("valid_drop", 128'(rk_valid), 128'h0);
        tick();
        check("done_clear", 128'(done), 128'h0);
        check("busy_clear", 128'(busy), 128'h0);
        check("done_once_t1", 128'(n_done - d0), 128'd1);
        check("queue_empty_t1", 128'(q.size()), 128'd0);

        // Random backpressure.
        d0 = n_done;
        push_fips(0);
        do_start(fips_in());
        for (int i = 0; i < 300 && !done; i++) begin
            rk_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if (!done) wait_done();
        rk_ready = 1'b1;
        tick();
        check("done_once_rand", 128'(n_done - d0), 128'd1);
        check("queue_empty_rand", 128'(q.size()), 128'd0);

        // Start asserted mid-sequence must be ignored.
        d0 = n_done;
        push_fips(0);
        do_start(fips_in());
        wait_round(4'd5);
        start = 1'b1; key_in = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        tick();
        start = 1'b0;
        wait_done();
        repeat (4) tick();
        check("done_once_midstart", 128'(n_done - d0), 128'd1);
        check("queue_empty_midstart", 128'(q.size()), 128'd0);
        check("idle_after_midstart", 128'(busy), 128'h0);

        // Reset in the middle, then a fresh key.
        d0 = n_done;
        push_fips(7);
        do_start(fips_in());
        wait_round(4'd6);
        rk_ready = 1'b0; rst_n = 1'b0;
        tick();
        check("midrst_rk_out", rk_out, 128'h0);
        check("midrst_rk_round", 128'(rk_round), 128'h0);
        check("midrst_rk_valid", 128'(rk_valid), 128'h0);
        check("midrst_busy", 128'(busy), 128'h0);
        check("midrst_done", 128'(done), 128'h0);
        check("midrst_queue", 128'(q.size()), 128'd0);
        rst_n = 1'b1; rk_ready = 1'b1;
        tick();
        push_model(128'h000102030405060708090a0b0c0d0e0f);
        do_start(128'h000102030405060708090a0b0c0d0e0f);
        repeat (c_LAT - 1) tick();
        check("newkey_first_round", 128'(rk_round), 128'd10);
        check("newkey_first_valid", 128'(rk_valid), 128'h1);
        wait_done();
        tick();
        check("done_once_newkey", 128'(n_done - d0), 128'd1);
        check("queue_empty_newkey", 128'(q.size()), 128'd0);

        // All-zero key.
        d0 = n_done;
        push_model(128'h0);
        do_start(128'h0);
        wait_done();
        repeat (3) tick();
        check("done_once_zero", 128'(n_done - d0), 128'd1);
        check("queue_empty_zero", 128'(q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
